// File: rtl/lbp_image_host.sv
`timescale 1ns/1ps
// lbp_image_host
// Host-side memory responder for an LBP engine.
//   * Holds a 2^AW-pixel gray image, loaded sequentially from address 0 by a
//     byte stream. gray_ready rises the cycle after the last pixel is written.
//   * Serves engine reads on the falling edge, so read data is valid within
//     the same cycle the address is issued.
//   * Captures engine result writes into a result RAM and counts them.
//   * Flags protocol violations in a sticky proto_err bit.
//   * Provides a registered readback port (border pixels read as 0).
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   load_valid, load_data      image byte stream
//   gray_ready                 image loaded, engine may start
//   gray_req, gray_addr        engine read request / address
//   gray_data                  engine read data (updated on negedge)
//   lbp_valid, lbp_addr,
//   lbp_data                   engine result write
//   finish                     engine signals end of frame
//   rd_addr, rd_data           result readback, 1-cycle latency
//   wr_count                   accepted result writes this frame (saturating)
//   done                       finish has been seen
//   proto_err                  sticky protocol-violation flag
module lbp_image_host #(
  parameter int AW     = 14,
  parameter int DW     = 8,
  parameter int IMG_W  = 128,
  parameter int EXP_WR = 15876
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  output logic          gray_ready,
  input  logic          gray_req,
  input  logic [AW-1:0] gray_addr,
  output logic [DW-1:0] gray_data,
  input  logic          lbp_valid,
  input  logic [AW-1:0] lbp_addr,
  input  logic [DW-1:0] lbp_data,
  input  logic          finish,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic [AW-1:0] wr_count,
  output logic          done,
  output logic          proto_err
);

  localparam int              HW       = AW / 2;          // bits per coordinate
  localparam int              DEPTH    = 1 << AW;
  localparam logic [AW-1:0]   ADDR_MAX = AW'(DEPTH - 1);
  localparam logic [HW-1:0]   EDGE_MAX = HW'(IMG_W - 1);
  localparam logic [AW-1:0]   EXP_CNT  = AW'(EXP_WR);

  typedef enum logic [1:0] {
    LOAD,
    SERVE,
    DONE
  } state_t;

  state_t        state, state_next;
  logic [AW-1:0] load_ptr;
  logic [DW-1:0] gray_ram   [DEPTH];
  logic [DW-1:0] result_ram [DEPTH];

  // Address is row-major {y, x}; a pixel on the outer ring has no full
  // 3x3 neighbourhood and therefore never carries a valid LBP code.
  function automatic logic is_border(input logic [AW-1:0] addr);
    logic [HW-1:0] x;
    logic [HW-1:0] y;
    x = addr[HW-1:0];
    y = addr[AW-1:HW];
    return (x == '0) || (x == EDGE_MAX) || (y == '0) || (y == EDGE_MAX);
  endfunction

  logic          load_wr;
  logic          load_last;
  logic          lbp_wr;
  logic [AW-1:0] wr_count_nxt;
  logic          violation;

  assign load_wr   = (state == LOAD) && load_valid;
  assign load_last = load_wr && (load_ptr == ADDR_MAX);
  assign lbp_wr    = (state == SERVE) && lbp_valid;

  // Count including a write in this same cycle, so a finish coinciding with
  // the last write is judged against the final total.
  assign wr_count_nxt = (lbp_wr && (wr_count != ADDR_MAX)) ? wr_count + AW'(1)
                                                           : wr_count;

  assign violation = ((state == LOAD)  && (gray_req || lbp_valid))
                  || ((state == DONE)  && lbp_valid)
                  || ((state == SERVE) && lbp_valid && is_border(lbp_addr))
                  || ((state == SERVE) && finish && (wr_count_nxt != EXP_CNT));

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (load_last) state_next = SERVE;
      SERVE:   if (finish)    state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LOAD;
      load_ptr   <= '0;
      wr_count   <= '0;
      gray_ready <= 1'b0;
      done       <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      state      <= state_next;
      wr_count   <= wr_count_nxt;
      gray_ready <= (state_next == SERVE);
      done       <= (state_next == DONE);
      proto_err  <= proto_err | violation;
      // Pointer stops at the last address; leaving LOAD ends the stream.
      if (load_wr && !load_last) load_ptr <= load_ptr + AW'(1);
    end
  end

  // NOTE: the RAM arrays have no reset; their contents survive reset and
  // are simply overwritten by the next load / frame.
  always_ff @(posedge clk) begin
    if (load_wr) gray_ram[load_ptr]   <= load_data;
    if (lbp_wr)  result_ram[lbp_addr] <= lbp_data;
  end

  // Falling-edge read: data settles half a cycle after the request is
  // launched, ahead of the engine's capturing rising edge.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      gray_data <= '0;
    end else if ((state == SERVE) && gray_req) begin
      gray_data <= gray_ram[gray_addr];
    end
  end

  // Readback samples the RAM before this edge's write lands (read-before-write).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= is_border(rd_addr) ? '0 : result_ram[rd_addr];
    end
  end

endmodule

// File: tb/tb_lbp_image_host.sv
`timescale 1ns/1ps
// Self-checking bench for lbp_image_host. The bench plays both the image
// loader and the LBP engine; expected values come from an image model and a
// golden LBP computed directly from that model.
module tb_lbp_image_host;

  localparam int AW  = 14;
  localparam int DW  = 8;
  localparam int N   = 16384;
  localparam int IW  = 128;
  localparam int EXP = 15876;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          gray_ready;
  logic          gray_req = 1'b0;
  logic [AW-1:0] gray_addr = '0;
  logic [DW-1:0] gray_data;
  logic          lbp_valid = 1'b0;
  logic [AW-1:0] lbp_addr = '0;
  logic [DW-1:0] lbp_data = '0;
  logic          finish = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] wr_count;
  logic          done;
  logic          proto_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] img     [N];
  logic [7:0] lbp_exp [N];

  lbp_image_host #(.AW(AW), .DW(DW), .IMG_W(IW), .EXP_WR(EXP)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data),
    .gray_ready(gray_ready),
    .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
    .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
    .finish(finish),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_count(wr_count), .done(done), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit border(input int p);
    int x;
    int y;
    x = p % IW;
    y = p / IW;
    return (x == 0) || (x == IW - 1) || (y == 0) || (y == IW - 1);
  endfunction

  // Bit k set when neighbour k >= centre; neighbours clockwise from top-left.
  function automatic logic [7:0] lbp_code(input int p);
    logic [7:0] c;
    c = img[p];
    return {img[p-1] >= c, img[p+IW-1] >= c, img[p+IW] >= c, img[p+IW+1] >= c,
            img[p+1] >= c, img[p-IW+1] >= c, img[p-IW] >= c, img[p-IW-1] >= c};
  endfunction

  // k-th interior pixel in raster order
  function automatic int interior(input int k);
    return (1 + k / (IW - 2)) * IW + 1 + k % (IW - 2);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    load_valid = 1'b0; gray_req = 1'b0; lbp_valid = 1'b0; finish = 1'b0;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    tick;
  endtask

  // Stream img[first .. first+count-1]; seen_ready flags gray_ready after
  // any strobe of the batch.
  task automatic load_strobes(input int first, input int count, input int gap_div,
                              output bit seen_ready);
    seen_ready = 1'b0;
    for (int i = first; i < first + count; i++) begin
      if (gap_div > 0 && $urandom_range(gap_div - 1, 0) == 0) begin
        load_valid = 1'b0;
        tick;
      end
      load_valid = 1'b1;
      load_data  = img[i];
      tick;
      if (gray_ready) seen_ready = 1'b1;
    end
    load_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset;
    apply_reset;
    total++; if (gray_ready !== 1'b0) begin bad++; $display("FAIL reset_gray_ready got=%0b want=0", gray_ready); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL reset_proto_err got=%0b want=0", proto_err); end
    total++; if (wr_count !== '0) begin bad++; $display("FAIL reset_wr_count got=%0d want=0", wr_count); end
    total++; if (gray_data !== '0) begin bad++; $display("FAIL reset_gray_data got=%0h want=0", gray_data); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got=%0h want=0", rd_data); end
  endtask

  task automatic test_gray_req_in_load;
    gray_req = 1'b1; gray_addr = 14'd3;
    tick;
    gray_req = 1'b0;
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL load_gray_req_err got=%0b want=1", proto_err); end
    apply_reset;
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL err_cleared_by_reset got=%0b want=0", proto_err); end
  endtask

  task automatic test_load_ramp;
    bit seen;
    for (int a = 0; a < N; a++) img[a] = 8'(a);
    load_strobes(0, N - 1, 32, seen);
    tick; tick;
    total++; if (seen || gray_ready !== 1'b0) begin bad++; $display("FAIL ready_after_16383 got=%0b/%0b want=0", seen, gray_ready); end
    load_strobes(N - 1, 1, 0, seen);
    total++; if (gray_ready !== 1'b1) begin bad++; $display("FAIL ready_after_16384 got=%0b want=1", gray_ready); end
  endtask

  task automatic test_load_ignored_in_serve;
    load_valid = 1'b1; load_data = 8'hFF;
    repeat (3) tick;
    load_valid = 1'b0;
    for (int a = 0; a < 3; a++) begin
      gray_req = 1'b1; gray_addr = 14'(a);
      @(negedge clk); #1;
      total++; if (gray_data !== img[a]) begin bad++; $display("FAIL load_ignored addr=%0d got=%0h want=%0h", a, gray_data, img[a]); end
      tick;
    end
    gray_req = 1'b0;
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL load_in_serve_err got=%0b want=0", proto_err); end
  endtask

  task automatic test_gray_read;
    int a;
    gray_req = 1'b1; gray_addr = 14'd129;
    @(negedge clk); #1;
    total++; if (gray_data !== 8'h81) begin bad++; $display("FAIL gray_129 got=%0h want=81", gray_data); end
    tick;
    gray_addr = 14'd130;
    @(negedge clk); #1;
    total++; if (gray_data !== 8'h82) begin bad++; $display("FAIL gray_130 got=%0h want=82", gray_data); end
    tick;
    gray_req = 1'b0; gray_addr = 14'd5;
    @(negedge clk); #1;
    total++; if (gray_data !== 8'h82) begin bad++; $display("FAIL gray_hold got=%0h want=82", gray_data); end
    tick;
    for (int i = 0; i < 16; i++) begin
      a = int'($urandom_range(N - 1, 0));
      gray_req = 1'b1; gray_addr = 14'(a);
      @(negedge clk); #1;
      total++; if (gray_data !== img[a]) begin bad++; $display("FAIL gray_rand addr=%0d got=%0h want=%0h", a, gray_data, img[a]); end
      tick;
    end
    gray_req = 1'b0;
  endtask

  task automatic test_lbp_write;
    lbp_valid = 1'b1; lbp_addr = 14'd129; lbp_data = 8'hA5;
    tick;
    lbp_valid = 1'b0;
    total++; if (wr_count !== 14'd1) begin bad++; $display("FAIL wr_count_1 got=%0d want=1", wr_count); end
    rd_addr = 14'd129; tick;
    total++; if (rd_data !== 8'hA5) begin bad++; $display("FAIL rd_129 got=%0h want=a5", rd_data); end
    rd_addr = 14'd0; tick;
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL rd_border0 got=%0h want=0", rd_data); end
    rd_addr = 14'd127; tick;
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL rd_border127 got=%0h want=0", rd_data); end
    // read-before-write on the same address
    lbp_valid = 1'b1; lbp_addr = 14'd131; lbp_data = 8'h22;
    tick;
    lbp_data = 8'h33; rd_addr = 14'd131;
    tick;
    lbp_valid = 1'b0;
    total++; if (rd_data !== 8'h22) begin bad++; $display("FAIL rd_before_wr got=%0h want=22", rd_data); end
    tick;
    total++; if (rd_data !== 8'h33) begin bad++; $display("FAIL rd_after_wr got=%0h want=33", rd_data); end
    total++; if (wr_count !== 14'd3) begin bad++; $display("FAIL wr_count_3 got=%0d want=3", wr_count); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL interior_wr_err got=%0b want=0", proto_err); end
  endtask

  task automatic test_finish_early;
    for (int i = 0; i < 97; i++) begin
      lbp_valid = 1'b1; lbp_addr = 14'(2 * IW + 1 + i); lbp_data = 8'($urandom);
      tick;
    end
    lbp_valid = 1'b0;
    total++; if (wr_count !== 14'd100) begin bad++; $display("FAIL wr_count_100 got=%0d want=100", wr_count); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL pre_finish_err got=%0b want=0", proto_err); end
    finish = 1'b1; tick; finish = 1'b0;
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL early_finish_err got=%0b want=1", proto_err); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL early_finish_done got=%0b want=1", done); end
    total++; if (gray_ready !== 1'b0) begin bad++; $display("FAIL early_finish_ready got=%0b want=0", gray_ready); end
    apply_reset;
  endtask

  task automatic test_reset_mid_serve;
    bit seen;
    for (int a = 0; a < N; a++) img[a] = 8'($urandom);
    load_strobes(0, N, 0, seen);
    total++; if (gray_ready !== 1'b1) begin bad++; $display("FAIL rand_load_ready got=%0b want=1", gray_ready); end
    lbp_valid = 1'b1; lbp_addr = 14'd5; lbp_data = 8'h5A;
    tick;
    lbp_valid = 1'b0;
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL border_wr_err got=%0b want=1", proto_err); end
    total++; if (wr_count !== 14'd1) begin bad++; $display("FAIL border_wr_count got=%0d want=1", wr_count); end
    for (int k = 0; k < 499; k++) begin
      lbp_valid = 1'b1; lbp_addr = 14'(interior(k)); lbp_data = 8'($urandom);
      tick;
    end
    lbp_valid = 1'b0;
    total++; if (wr_count !== 14'd500) begin bad++; $display("FAIL wr_count_500 got=%0d want=500", wr_count); end
    reset = 1'b1;
    #1;
    total++; if (wr_count !== '0) begin bad++; $display("FAIL mid_reset_wr_count got=%0d want=0", wr_count); end
    total++; if (gray_ready !== 1'b0) begin bad++; $display("FAIL mid_reset_ready got=%0b want=0", gray_ready); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL mid_reset_err got=%0b want=0", proto_err); end
    tick;
    reset = 1'b0;
    tick;
    // Reload: only a full new image may raise gray_ready again.
    load_strobes(0, N - 1, 0, seen);
    tick;
    total++; if (seen || gray_ready !== 1'b0) begin bad++; $display("FAIL reload_early_ready got=%0b/%0b want=0", seen, gray_ready); end
    load_strobes(N - 1, 1, 0, seen);
    total++; if (gray_ready !== 1'b1) begin bad++; $display("FAIL reload_ready got=%0b want=1", gray_ready); end
  endtask

  task automatic test_full_frame;
    int a;
    int errs;
    int first_bad;
    logic [7:0] want;
    for (int p = 0; p < N; p++) lbp_exp[p] = border(p) ? 8'h00 : lbp_code(p);
    for (int i = 0; i < 32; i++) begin
      a = int'($urandom_range(N - 1, 0));
      gray_req = 1'b1; gray_addr = 14'(a);
      @(negedge clk); #1;
      total++; if (gray_data !== img[a]) begin bad++; $display("FAIL frame_gray addr=%0d got=%0h want=%0h", a, gray_data, img[a]); end
      tick;
    end
    gray_req = 1'b0;
    for (int k = 0; k < EXP; k++) begin
      if ($urandom_range(15, 0) == 0) begin
        lbp_valid = 1'b0; finish = 1'b0;
        tick;
      end
      lbp_valid = 1'b1;
      lbp_addr  = 14'(interior(k));
      lbp_data  = lbp_exp[interior(k)];
      finish    = (k == EXP - 1);   // finish together with the last write
      tick;
    end
    lbp_valid = 1'b0; finish = 1'b0;
    total++; if (wr_count !== 14'(EXP)) begin bad++; $display("FAIL frame_wr_count got=%0d want=%0d", wr_count, EXP); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL frame_err got=%0b want=0", proto_err); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL frame_done got=%0b want=1", done); end
    total++; if (gray_ready !== 1'b0) begin bad++; $display("FAIL frame_ready got=%0b want=0", gray_ready); end
    errs = 0; first_bad = -1;
    for (int p = 0; p < N; p++) begin
      rd_addr = 14'(p);
      tick;
      if (rd_data !== lbp_exp[p]) begin
        errs++;
        if (first_bad < 0) first_bad = p;
      end
    end
    total++; if (errs != 0) begin bad++; $display("FAIL frame_readback wrong=%0d want=0 first_addr=%0d", errs, first_bad); end
    // Writes after done are dropped and flagged.
    want = lbp_exp[129];
    lbp_valid = 1'b1; lbp_addr = 14'd129; lbp_data = ~want;
    tick;
    lbp_valid = 1'b0;
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL after_done_err got=%0b want=1", proto_err); end
    total++; if (wr_count !== 14'(EXP)) begin bad++; $display("FAIL after_done_count got=%0d want=%0d", wr_count, EXP); end
    rd_addr = 14'd129; tick;
    total++; if (rd_data !== want) begin bad++; $display("FAIL after_done_data got=%0h want=%0h", rd_data, want); end
  endtask

  initial begin
    test_reset;
    test_gray_req_in_load;
    test_load_ramp;
    test_load_ignored_in_serve;
    test_gray_read;
    test_lbp_write;
    test_finish_early;
    test_reset_mid_serve;
    test_full_frame;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
